// File: rtl/ah_snoop_dedup_writer.sv
// ah_snoop_dedup_writer: snoops each upstream request against the FIFO and pushes only misses.
// Latency >= SNOOP_LAT+3 cycles per request; wready low stalls in PUSH with in_ready low.
// Optional macro AH_DEDUP_STATS_EN adds saturating pass/drop counters.
module ah_snoop_dedup_writer #(
    parameter int DW        = 64,
    parameter int SNOOP_LAT = 1,
    parameter int CNTW      = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] wdata,
    output logic          wvalid,
    input  logic          wready,
    output logic [DW-1:0] sdata,
    output logic          svalid,
    input  logic          smatch,
    output logic          drop_pulse,
    output logic          busy
`ifdef AH_DEDUP_STATS_EN
    ,
    output logic [CNTW-1:0] pass_cnt,
    output logic [CNTW-1:0] drop_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SNOOP = 3'd1,
        WAIT  = 3'd2,
        PUSH  = 3'd3,
        DROP  = 3'd4
    } state_t;

    localparam logic [2:0] LAT_M1 = (SNOOP_LAT > 0) ? 3'(SNOOP_LAT - 1) : 3'd0;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    cnt;
    logic [2:0]    cnt_nxt;
    logic [DW-1:0] hold;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            cnt   <= 3'd0;
            hold  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && in_valid)
                hold <= in_data;
        end
    end

    // smatch is only looked at in the single decision cycle
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (in_valid)
                    state_nxt = SNOOP;
            end
            SNOOP: begin
                if (SNOOP_LAT == 0) begin
                    state_nxt = smatch ? DROP : PUSH;
                end else begin
                    cnt_nxt   = LAT_M1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 3'd0)
                    state_nxt = smatch ? DROP : PUSH;
                else
                    cnt_nxt = cnt - 3'd1;
            end
            PUSH: begin
                if (wready)
                    state_nxt = IDLE;
            end
            DROP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready   = rstn && (state == IDLE);
    assign svalid     = (state == SNOOP);
    assign wvalid     = (state == PUSH);
    assign drop_pulse = (state == DROP);
    assign busy       = (state != IDLE);
    assign wdata      = hold;
    assign sdata      = hold;

`ifdef AH_DEDUP_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pass_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (state == PUSH && wready && pass_cnt != '1)
                pass_cnt <= pass_cnt + 1'b1;
            if (state == DROP && drop_cnt != '1)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    // statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_ah_snoop_dedup_writer.sv
// Bench for ah_snoop_dedup_writer: four instances (SNOOP_LAT 1,0,3,7) driven against a FIFO model.
module tb_ah_snoop_dedup_writer;

    localparam int NI = 4;

    logic        clk;
    logic        rstn;
    logic [63:0] in_data    [NI];
    logic        in_valid   [NI];
    logic        in_ready   [NI];
    logic [63:0] wdata      [NI];
    logic        wvalid     [NI];
    logic        wready     [NI];
    logic [63:0] sdata      [NI];
    logic        svalid     [NI];
    logic        smatch     [NI];
    logic        drop_pulse [NI];
    logic        busy       [NI];
`ifdef AH_DEDUP_STATS_EN
    logic [15:0] pass_cnt   [NI];
    logic [15:0] drop_cnt   [NI];
`endif

    int n_chk = 0;
    int n_bad = 0;

    // FIFO model: contents of each instance's downstream FIFO, front at index 0
    logic [63:0] fmem [NI][8];
    int          fcnt [NI];
    int          exp_wr [NI];
    int          exp_dp [NI];
    int          exp_pass [NI];
    int          exp_drop [NI];
    int          hs_cnt [NI];
    int          dp_cnt [NI];

    function automatic int lat_of(input int k);
        case (k)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 7;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7;
        ah_snoop_dedup_writer #(.DW(64), .SNOOP_LAT(LAT), .CNTW(16)) u_dut (
            .clk        (clk),
            .rstn       (rstn),
            .in_data    (in_data[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .wdata      (wdata[g]),
            .wvalid     (wvalid[g]),
            .wready     (wready[g]),
            .sdata      (sdata[g]),
            .svalid     (svalid[g]),
            .smatch     (smatch[g]),
            .drop_pulse (drop_pulse[g]),
            .busy       (busy[g])
`ifdef AH_DEDUP_STATS_EN
            ,
            .pass_cnt   (pass_cnt[g]),
            .drop_cnt   (drop_cnt[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (wvalid[k] && wready[k]) hs_cnt[k]++;
            if (drop_pulse[k]) dp_cnt[k]++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit fifo_has(input int k, input logic [63:0] d);
        for (int i = 0; i < 8; i++)
            if (i < fcnt[k] && fmem[k][i] == d) return 1'b1;
        return 1'b0;
    endfunction

    task automatic fifo_pop(input int k);
        if (fcnt[k] > 0) begin
            for (int i = 0; i < 7; i++) fmem[k][i] = fmem[k][i+1];
            fcnt[k]--;
        end
    endtask

    task automatic fifo_push(input int k, input logic [63:0] d);
        if (fcnt[k] == 8) fifo_pop(k);
        fmem[k][fcnt[k]] = d;
        fcnt[k]++;
    endtask

    // mode 0: smatch from FIFO model in the sampled cycle, random elsewhere
    // mode 1: smatch high only in non-sampled cycles; mode 2: high only in the sampled cycle
    task automatic run_req(input int k, input logic [63:0] d, input int mode,
                           input int stall, input bit rst_mid);
        int lat;
        bit hit;
        bit s;
        lat = lat_of(k);
        hit = 1'b0;
        chk("idle_rdy", 64'(in_ready[k]), 64'd1);
        chk("idle_busy", 64'(busy[k]), 64'd0);
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_data[k]  = {$urandom, $urandom};
        chk("snoop_vld", 64'(svalid[k]), 64'd1);
        chk("snoop_dat", sdata[k], d);
        chk("snoop_rdy", 64'(in_ready[k]), 64'd0);
        for (int c = 0; c <= lat; c++) begin
            if (c > 0) begin
                @(negedge clk);
                chk("wait_svld", 64'(svalid[k]), 64'd0);
                chk("wait_busy", 64'(busy[k]), 64'd1);
                chk("wait_wvld", 64'(wvalid[k]), 64'd0);
            end
            if (c == lat) begin
                s = (mode == 0) ? fifo_has(k, d) : (mode == 2);
                hit = s;
            end else begin
                s = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            end
            smatch[k] = s;
        end
        @(negedge clk);
        smatch[k] = 1'($urandom_range(0, 1));
        if (hit) begin
            chk("drop_pls", 64'(drop_pulse[k]), 64'd1);
            chk("drop_wvld", 64'(wvalid[k]), 64'd0);
            exp_dp[k]++;
            exp_drop[k]++;
            @(negedge clk);
            chk("drop_once", 64'(drop_pulse[k]), 64'd0);
            chk("drop_rdy", 64'(in_ready[k]), 64'd1);
        end else begin
            for (int i = 0; i < stall; i++) begin
                wready[k] = 1'b0;
                chk("stall_wvld", 64'(wvalid[k]), 64'd1);
                chk("stall_wdat", wdata[k], d);
                chk("stall_rdy", 64'(in_ready[k]), 64'd0);
                if (rst_mid && i == stall - 1) begin
                    rstn = 1'b0;
                    @(negedge clk);
                    chk("rst_wvld", 64'(wvalid[k]), 64'd0);
                    chk("rst_busy", 64'(busy[k]), 64'd0);
                    chk("rst_rdy", 64'(in_ready[k]), 64'd0);
                    rstn = 1'b1;
                    wready[k] = 1'b1;
                    for (int j = 0; j < NI; j++) begin
                        exp_pass[j] = 0;
                        exp_drop[j] = 0;
                    end
                    repeat (3) begin
                        @(negedge clk);
                        chk("post_rst_wvld", 64'(wvalid[k]), 64'd0);
                    end
                    return;
                end
                @(negedge clk);
            end
            wready[k] = 1'b1;
            chk("push_wvld", 64'(wvalid[k]), 64'd1);
            chk("push_wdat", wdata[k], d);
            fifo_push(k, d);
            exp_wr[k]++;
            exp_pass[k]++;
            @(negedge clk);
            chk("push_done", 64'(wvalid[k]), 64'd0);
            chk("push_rdy", 64'(in_ready[k]), 64'd1);
        end
    endtask

    initial begin
        rstn = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_data[k]  = 64'hDEAD_BEEF_0000_0000 + 64'(k);
            in_valid[k] = 1'b1;
            wready[k]   = 1'b1;
            smatch[k]   = 1'b0;
            fcnt[k]     = 0;
            exp_wr[k]   = 0;
            exp_dp[k]   = 0;
            exp_pass[k] = 0;
            exp_drop[k] = 0;
            hs_cnt[k]   = 0;
            dp_cnt[k]   = 0;
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_in_rdy", 64'(in_ready[k]), 64'd0);
            chk("rst_wvalid", 64'(wvalid[k]), 64'd0);
            chk("rst_svalid", 64'(svalid[k]), 64'd0);
            chk("rst_drop", 64'(drop_pulse[k]), 64'd0);
            chk("rst_busy", 64'(busy[k]), 64'd0);
            chk("rst_sdata", sdata[k], 64'd0);
            chk("rst_wdata", wdata[k], 64'd0);
`ifdef AH_DEDUP_STATS_EN
            chk("rst_pass_cnt", 64'(pass_cnt[k]), 64'd0);
            chk("rst_drop_cnt", 64'(drop_cnt[k]), 64'd0);
`endif
        end
        rstn = 1'b1;
        for (int k = 0; k < NI; k++) in_valid[k] = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) chk("rel_in_rdy", 64'(in_ready[k]), 64'd1);

        // duplicate: second identical request is dropped
        run_req(0, 64'hA5A5, 0, 0, 1'b0);
        run_req(0, 64'hA5A5, 0, 0, 1'b0);
`ifdef AH_DEDUP_STATS_EN
        chk("dup_pass_cnt", 64'(pass_cnt[0]), 64'd1);
        chk("dup_drop_cnt", 64'(drop_cnt[0]), 64'd1);
`endif

        // miss path and a 10-cycle backpressure hold
        run_req(0, 64'h1122334455667788, 0, 0, 1'b0);
        run_req(0, 64'h0BAD_F00D_CAFE_0001, 0, 10, 1'b0);

        // latency sweep: smatch outside the sampled cycle is ignored
        for (int k = 0; k < NI; k++) begin
            run_req(k, 64'h5000_0000_0000_0000 + 64'(k), 1, 1, 1'b0);
            run_req(k, 64'h6000_0000_0000_0000 + 64'(k), 2, 0, 1'b0);
        end

        // randomized traffic with a small data pool so duplicates are frequent
        for (int r = 0; r < 300; r++) begin
            int k;
            logic [63:0] d;
            k = $urandom_range(0, NI - 1);
            if ($urandom_range(0, 3) != 0) d = 64'($urandom_range(0, 7));
            else d = {$urandom, $urandom};
            run_req(k, d, 0, $urandom_range(0, 3), 1'b0);
            if ($urandom_range(0, 2) == 0) fifo_pop(k);
        end

        for (int k = 0; k < NI; k++) begin
`ifdef AH_DEDUP_STATS_EN
            chk("pass_cnt", 64'(pass_cnt[k]), 64'(exp_pass[k]));
            chk("drop_cnt", 64'(drop_cnt[k]), 64'(exp_drop[k]));
`endif
        end

        // reset while PUSH is stalled: the held entry is never written
        run_req(0, 64'h7777_0000_1234_5678, 1, 2, 1'b1);
        run_req(0, 64'h7777_0000_1234_5679, 1, 0, 1'b0);

        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("writes", 64'(hs_cnt[k]), 64'(exp_wr[k]));
            chk("drops", 64'(dp_cnt[k]), 64'(exp_dp[k]));
`ifdef AH_DEDUP_STATS_EN
            chk("pass_cnt_end", 64'(pass_cnt[k]), 64'(exp_pass[k]));
            chk("drop_cnt_end", 64'(drop_cnt[k]), 64'(exp_drop[k]));
`endif
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
